// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UL constants, arbiter FSM state and burst beat-count helper.
// Combinational only: no clock, no latency, no backpressure of its own.
package tl_arb_pkg;

  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arbState_t;

  // A Get carries no data on A, so it is always one beat regardless of size.
  function automatic logic [CNT_W-1:0] beatCount(
    input logic [2:0]  opcode,
    input logic [2:0]  size,
    input logic [2:0]  beatBytesLog2
  );
    if (opcode == OP_GET || size <= beatBytesLog2) begin
      return CNT_W'(1);
    end
    return CNT_W'(1) << (size - beatBytesLog2);
  endfunction

endpackage

// File: rtl/tl_rr_grant2.sv
// Two-way round-robin grant with a hold that pins the choice while a request stalls.
// Zero latency grant; pointer and hold update on the rising clock edge only.
import tl_arb_pkg::*;

module tl_rr_grant2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       stall,
  input  logic       advance,
  output logic       grant
);

  logic lastGrant;
  logic holdVld;
  logic holdIdx;
  logic lastEff;
  logic holdEff;
  logic rrPick;

  // Outputs during reset must already reflect the reset-state registers.
  assign lastEff = reset ? 1'b1 : lastGrant;
  assign holdEff = reset ? 1'b0 : holdVld;

  always_comb begin
    rrPick = 1'b0;
    if (valid == 2'b11) begin
      rrPick = ~lastEff;
    end else if (valid[1]) begin
      rrPick = 1'b1;
    end
  end

  // A held client that withdrew its request no longer pins the grant.
  assign grant = (holdEff && valid[holdIdx]) ? holdIdx : rrPick;

  always_ff @(posedge clock) begin
    if (reset) begin
      lastGrant <= 1'b1;
      holdVld   <= 1'b0;
      holdIdx   <= 1'b0;
    end else begin
      if (advance) begin
        lastGrant <= grant;
      end
      holdVld <= stall;
      holdIdx <= grant;
    end
  end

endmodule

// File: rtl/tl_a_arbiter_2to1.sv
// 2:1 TileLink-UL arbiter: round-robin A with burst lock, D routed by source[2]; TL_ARB_PERF_EN adds grant counters.
// Zero-latency A and D paths; backpressure reaches only the granted (A) or addressed (D) client.
import tl_arb_pkg::*;

module tl_a_arbiter_2to1 #(
  parameter int ADDR_W = 36,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  output logic                auto_in_0_a_ready,
  input  logic                auto_in_0_a_valid,
  input  logic [2:0]          auto_in_0_a_bits_opcode,
  input  logic [2:0]          auto_in_0_a_bits_size,
  input  logic [1:0]          auto_in_0_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_0_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_0_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_0_a_bits_data,
  input  logic                auto_in_0_d_ready,
  output logic                auto_in_0_d_valid,
  output logic [2:0]          auto_in_0_d_bits_opcode,
  output logic [2:0]          auto_in_0_d_bits_size,
  output logic [1:0]          auto_in_0_d_bits_source,
  output logic [DATA_W-1:0]   auto_in_0_d_bits_data,
  output logic                auto_in_1_a_ready,
  input  logic                auto_in_1_a_valid,
  input  logic [2:0]          auto_in_1_a_bits_opcode,
  input  logic [2:0]          auto_in_1_a_bits_size,
  input  logic [1:0]          auto_in_1_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_1_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_1_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_1_a_bits_data,
  input  logic                auto_in_1_d_ready,
  output logic                auto_in_1_d_valid,
  output logic [2:0]          auto_in_1_d_bits_opcode,
  output logic [2:0]          auto_in_1_d_bits_size,
  output logic [1:0]          auto_in_1_d_bits_source,
  output logic [DATA_W-1:0]   auto_in_1_d_bits_data,
  input  logic                auto_out_a_ready,
  output logic                auto_out_a_valid,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_size,
  output logic [2:0]          auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_d_ready,
  input  logic                auto_out_d_valid,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [2:0]          auto_out_d_bits_size,
  input  logic [2:0]          auto_out_d_bits_source,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data
`ifdef TL_ARB_PERF_EN
  ,
  output logic [31:0]         perf_grant_0,
  output logic [31:0]         perf_grant_1
`endif
);

  localparam logic [2:0] BEAT_LOG2 = 3'($clog2(DATA_W / 8));

  arbState_t        state;
  arbState_t        stateEff;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] reqBeats;
  logic             lockIdx;
  logic             rrGrant;
  logic             grantIdx;
  logic [1:0]       inValid;
  logic             aFire;
  logic             firstFire;
  logic             stall;

  assign inValid  = {auto_in_1_a_valid, auto_in_0_a_valid};
  assign stateEff = reset ? IDLE : state;
  assign grantIdx = (stateEff == BURST) ? lockIdx : rrGrant;

  assign auto_out_a_valid  = (stateEff == BURST) ? inValid[lockIdx] : |inValid;
  assign auto_in_0_a_ready = auto_out_a_ready && !grantIdx;
  assign auto_in_1_a_ready = auto_out_a_ready &&  grantIdx;

  assign aFire     = auto_out_a_valid && auto_out_a_ready;
  assign firstFire = aFire && (stateEff == IDLE);
  assign stall     = (stateEff == IDLE) && inValid[rrGrant] && !auto_out_a_ready;

  assign auto_out_a_bits_opcode  = grantIdx ? auto_in_1_a_bits_opcode  : auto_in_0_a_bits_opcode;
  assign auto_out_a_bits_size    = grantIdx ? auto_in_1_a_bits_size    : auto_in_0_a_bits_size;
  assign auto_out_a_bits_source  = {grantIdx, grantIdx ? auto_in_1_a_bits_source : auto_in_0_a_bits_source};
  assign auto_out_a_bits_address = grantIdx ? auto_in_1_a_bits_address : auto_in_0_a_bits_address;
  assign auto_out_a_bits_mask    = grantIdx ? auto_in_1_a_bits_mask    : auto_in_0_a_bits_mask;
  assign auto_out_a_bits_data    = grantIdx ? auto_in_1_a_bits_data    : auto_in_0_a_bits_data;

  assign reqBeats = beatCount(auto_out_a_bits_opcode, auto_out_a_bits_size, BEAT_LOG2);

  tl_rr_grant2 rrGrant2 (
    .clock   (clock),
    .reset   (reset),
    .valid   (inValid),
    .stall   (stall),
    .advance (firstFire),
    .grant   (rrGrant)
  );

  // The last beat's fire drops back to IDLE so the next cycle can re-arbitrate.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      lockIdx   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (firstFire && reqBeats > CNT_W'(1)) begin
            state     <= BURST;
            lockIdx   <= grantIdx;
            remaining <= reqBeats - CNT_W'(1);
          end
        end
        BURST: begin
          if (aFire) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign auto_out_d_ready        = auto_out_d_bits_source[2] ? auto_in_1_d_ready : auto_in_0_d_ready;
  assign auto_in_0_d_valid       = auto_out_d_valid && !auto_out_d_bits_source[2];
  assign auto_in_1_d_valid       = auto_out_d_valid &&  auto_out_d_bits_source[2];
  assign auto_in_0_d_bits_opcode = auto_out_d_bits_opcode;
  assign auto_in_1_d_bits_opcode = auto_out_d_bits_opcode;
  assign auto_in_0_d_bits_size   = auto_out_d_bits_size;
  assign auto_in_1_d_bits_size   = auto_out_d_bits_size;
  assign auto_in_0_d_bits_source = auto_out_d_bits_source[1:0];
  assign auto_in_1_d_bits_source = auto_out_d_bits_source[1:0];
  assign auto_in_0_d_bits_data   = auto_out_d_bits_data;
  assign auto_in_1_d_bits_data   = auto_out_d_bits_data;

`ifdef TL_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grant_0 <= '0;
      perf_grant_1 <= '0;
    end else if (firstFire) begin
      if (grantIdx) begin
        perf_grant_1 <= perf_grant_1 + 32'd1;
      end else begin
        perf_grant_0 <= perf_grant_0 + 32'd1;
      end
    end
  end
`endif

endmodule
